// File: rtl/bop_pkg.sv
// Types and helpers shared by the best-offset prefetcher and its issue scheduler.
package bop_pkg;

    localparam int BOP_ADDR_W  = 64;
    localparam int BOP_LOGLINE = 6;

    typedef logic [BOP_ADDR_W-1:0] line_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } sched_state_e;

    // Clear the byte-offset bits so the address names a whole cache line.
    function automatic line_addr_t line_align(input line_addr_t addr, input int unsigned logline);
        line_addr_t mask;
        mask = '1;
        mask = mask << logline;
        return addr & mask;
    endfunction

endpackage

// File: rtl/bop_prefetch_issue_scheduler_if.sv
// Candidate input and lower-level prefetch port of the issue scheduler.
interface bop_prefetch_issue_scheduler_if #(
    parameter int WIDTH = 64
);
    logic             cand_valid_i;
    logic [WIDTH-1:0] cand_addr_i;
    logic             lo_prefetch_valid_o;
    logic [WIDTH-1:0] lo_prefetch_address_o;
    logic             lo_ready_i;
    logic             lo_done_i;

    // Environment side: supplies candidates, accepts requests, returns completions.
    modport master (
        output cand_valid_i, cand_addr_i, lo_ready_i, lo_done_i,
        input  lo_prefetch_valid_o, lo_prefetch_address_o
    );

    // Scheduler side.
    modport slave (
        input  cand_valid_i, cand_addr_i, lo_ready_i, lo_done_i,
        output lo_prefetch_valid_o, lo_prefetch_address_o
    );
endinterface

// File: rtl/bop_dedup_fifo.sv
// In-order line queue with a parallel match of the push data against every
// valid entry, a single-cycle flush and an occupancy count.
module bop_dedup_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_match,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_count   = r_wr - r_rd;
    assign o_head    = r_mem[r_rd[AW-1:0]];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // Compare the incoming line against every occupied slot at once.
    always_comb begin
        o_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_mem[i] == i_data)) o_match = 1'b1;
        end
    end

    // Pointers and slot-valid bits; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_vld <= '0;
        end else begin
            if (w_do_push) begin
                r_vld[r_wr[AW-1:0]] <= 1'b1;
                r_wr                <= r_wr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_vld[r_rd[AW-1:0]] <= 1'b0;
                r_rd                <= r_rd + (AW+1)'(1);
            end
        end
    end

    // Line storage; contents are meaningless until the slot-valid bit is set.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/bop_prefetch_issue_scheduler.sv
// Queues best-offset prefetch candidates as cache lines, drops duplicates and
// overflow, and issues them to the lower level under a credit limit.
module bop_prefetch_issue_scheduler
    import bop_pkg::*;
#(
    parameter int WIDTH        = BOP_ADDR_W,
    parameter int DEPTH        = 8,
    parameter int LOGLINE      = BOP_LOGLINE,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable_i,
    input  logic                              flush_i,
    bop_prefetch_issue_scheduler_if.slave     bus,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
    output logic [$clog2(DEPTH+1)-1:0]        queue_count_o,
    output logic [CNT_WIDTH-1:0]              drop_count_o
);
    localparam int IW = $clog2(MAX_INFLIGHT+1);
    localparam int CW = $clog2(DEPTH+1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [WIDTH-1:0]     w_line, w_head;
    logic                 w_match, w_full, w_empty;
    logic [CW-1:0]        w_count;
    logic                 w_dup, w_push, w_drop, w_hs, w_done, w_credit, w_present;
    logic                 w_valid_nxt, w_credit_nxt, w_q_empty_nxt, w_idle_nxt;
    logic [IW-1:0]        w_inflight_nxt;
    logic [CW:0]          w_cnt_nxt;
    logic [IW:0]          w_used;

    logic                 r_valid;
    logic [WIDTH-1:0]     r_addr;
    logic [IW-1:0]        r_inflight;
    logic [CNT_WIDTH-1:0] r_drop;
    sched_state_e         r_state;

    assign w_line = WIDTH'(line_align(line_addr_t'(bus.cand_addr_i), LOGLINE));

    bop_dedup_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_line),
        .i_pop   (w_present),
        .i_flush (flush_i),
        .o_head  (w_head),
        .o_match (w_match),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A presented request holds a credit from presentation until handshake.
    assign w_dup     = w_match || (r_valid && (r_addr == w_line));
    assign w_push    = bus.cand_valid_i && !flush_i && !w_dup && !w_full;
    assign w_drop    = bus.cand_valid_i && !flush_i && (w_dup || w_full);
    assign w_hs      = r_valid && bus.lo_ready_i;
    assign w_done    = bus.lo_done_i && (r_inflight != '0);
    assign w_used    = {1'b0, r_inflight} + {{IW{1'b0}}, r_valid};
    assign w_credit  = w_used < (IW+1)'(MAX_INFLIGHT);
    assign w_present = (!r_valid || w_hs) && !w_empty && enable_i && !flush_i && w_credit;

    // Post-update view used to pick the next scheduler state.
    assign w_valid_nxt   = w_present || (r_valid && !w_hs);
    assign w_cnt_nxt     = flush_i ? '0
                         : {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_present);
    assign w_q_empty_nxt = (w_cnt_nxt == '0);
    assign w_idle_nxt    = w_q_empty_nxt && !w_valid_nxt;
    assign w_credit_nxt  = ({1'b0, w_inflight_nxt} + {{IW{1'b0}}, w_valid_nxt})
                           < (IW+1)'(MAX_INFLIGHT);

    // Net credit change: a handshake takes one, a completion returns one.
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_hs && !w_done)      w_inflight_nxt = r_inflight + IW'(1);
        else if (!w_hs && w_done) w_inflight_nxt = r_inflight - IW'(1);
    end

    // Output request register: load the head, hold until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (w_present) begin
            r_valid <= 1'b1;
            r_addr  <= w_head;
        end else if (w_hs) begin
            r_valid <= 1'b0;
        end
    end

    // In-flight credit and saturating drop counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (w_drop) r_drop <= sat_inc(r_drop);
        end
    end

    // Scheduler state; a flush edge always passes through FLUSH for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (flush_i) begin
            r_state <= FLUSH;
        end else begin
            case (r_state)
                FLUSH:   r_state <= w_idle_nxt ? IDLE : ISSUE;
                default: begin
                    if (w_idle_nxt)                                  r_state <= IDLE;
                    else if (w_valid_nxt || (enable_i && w_credit_nxt)) r_state <= ISSUE;
                    else                                             r_state <= STALL;
                end
            endcase
        end
    end

    assign bus.lo_prefetch_valid_o   = r_valid;
    assign bus.lo_prefetch_address_o = r_addr;
    assign inflight_o                = r_inflight;
    assign queue_count_o             = w_count;
    assign drop_count_o              = r_drop;

endmodule

// File: doc/bop_prefetch_issue_scheduler.md
Name: bop_prefetch_issue_scheduler

Overview:
- Sits between the best-offset prefetcher's candidate output and the lower-level cache prefetch port.
- Buffers prefetch candidates in a small in-order queue and line-aligns them.
- Drops duplicates and overflow.
- Issues candidates on a valid/ready handshake, throttled by an in-flight credit limit, with enable and flush control.

Parameters:
- WIDTH, 64, address width.
- DEPTH, 8, queue entries; power of two, at least 2.
- LOGLINE, 6, log2 of cache line bytes; low bits cleared on accept.
- MAX_INFLIGHT, 4, maximum issued-but-not-completed prefetches.
- CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- enable_i  in  1  permit new issues
- flush_i  in  1  discard queued, unpresented candidates
- cand_valid_i  in  1  prefetch candidate present this cycle
- cand_addr_i  in  WIDTH  candidate byte address
- lo_prefetch_valid_o  out  1  prefetch request to lower level
- lo_prefetch_address_o  out  WIDTH  line-aligned prefetch address
- lo_ready_i  in  1  lower level accepts request
- lo_done_i  in  1  one prefetch completed (returns one credit)
- inflight_o  out  $clog2(MAX_INFLIGHT+1)  current in-flight count
- queue_count_o  out  $clog2(DEPTH+1)  occupied queue entries
- drop_count_o  out  CNT_WIDTH  saturating count of dropped candidates

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs are 0 at reset, all queue entries invalid, FSM in IDLE. Reset mid-handshake abandons the presented request.
- Accept: line = cand_addr_i with bits [LOGLINE-1:0] zeroed. A candidate is dropped, and drop_count_o incremented, if any of these hold:
  - the line matches a valid queue entry;
  - the line matches the presented request while lo_prefetch_valid_o=1;
  - the queue is full at the start of the cycle (no same-cycle pass-through freeing).
  Otherwise the line is written at the tail on the clock edge.
- drop_count_o saturates at all-ones.
- Present: when lo_prefetch_valid_o=0, queue non-empty, enable_i=1, flush_i=0 and inflight_o<MAX_INFLIGHT, the head is popped into the output register. lo_prefetch_valid_o=1 appears the next cycle.
- Minimum latency from cand_valid_i into an empty idle block to lo_prefetch_valid_o is 2 cycles.
- Handshake:
  - Once asserted, lo_prefetch_valid_o and the address hold stable until lo_ready_i=1, regardless of enable_i or flush_i.
  - The transfer completes on the cycle valid&ready=1. valid drops the next cycle unless a new head is presented back-to-back in that same edge.
  - Sustained throughput is 1 per cycle.
- Credits:
  - inflight_o increments on a handshake and decrements on lo_done_i.
  - A handshake and lo_done_i in the same cycle leave it unchanged.
  - lo_done_i at 0 is ignored; it never wraps.
  - A handshake is possible only when a credit was reserved at presentation, so inflight_o never exceeds MAX_INFLIGHT.
- Flush: on the edge where flush_i=1, all queue entries are invalidated and queue_count_o goes to 0. A candidate arriving in the same cycle is dropped but not counted. The presented request is unaffected.
- FSM (state held in a register):
  - IDLE: queue empty, no presented request.
  - ISSUE: request presented or presentable.
  - STALL: queue non-empty but no credit or enable_i=0.
  - FLUSH: a one-cycle state entered when flush_i=1, then returning to IDLE or ISSUE.
  - Transitions are evaluated each cycle from the queue, credit and enable conditions after that cycle's updates.
- Queue pointers wrap modulo DEPTH. Full/empty are derived from an extra pointer bit.

Decomposition:
- Package bop_pkg holds:
  - the line_addr_t typedef and the LOGLINE/line-align function, shared with the prefetcher;
  - the sched_state_e enum (IDLE, ISSUE, STALL, FLUSH).
- One natural sub-module: bop_dedup_fifo. It is a DEPTH-entry FIFO with parallel CAM match on push, a flush clear, and count output.

Test Plan:
- Single candidate 0x1234 into an idle block with enable_i=1 and lo_ready_i=1: lo_prefetch_valid_o rises 2 cycles later with address 0x1200, and inflight_o becomes 1 after the handshake.
- Candidates 0x1000, 0x1008, 0x1000 on consecutive cycles: one request 0x1000 is issued and drop_count_o=2.
- MAX_INFLIGHT=4, 6 distinct lines, lo_done_i held 0: exactly 4 issued, FSM in STALL, queue_count_o=2. One lo_done_i pulse leads to a fifth issue.
- Fill 8 distinct lines with enable_i=0, then send a 9th: the 9th is dropped and drop_count_o=1. Raise enable_i: 8 issues in order at 1 per cycle.
- Presented request held with lo_ready_i=0 while flush_i is pulsed with 3 lines queued: valid and address stay stable, queue_count_o goes to 0, and only that one request issues once lo_ready_i=1.
- Handshake and lo_done_i in the same cycle with inflight_o=2: it stays 2. rst asserted mid-request: all outputs are 0 the next cycle.
